// File: rtl/btb_update_ctrl_if.sv
// Update request channel from branch resolution into btb_update_ctrl.
// The master drives resolved branches; the slave answers with upd_ready.
interface btb_update_ctrl_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;

  modport master (output upd_valid, output upd_pc, output upd_target, output upd_taken,
                  input  upd_ready);
  modport slave  (input  upd_valid, input  upd_pc, input  upd_target, input  upd_taken,
                  output upd_ready);
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB update sequencer: 2-entry request FIFO plus IDLE/READ/WRITE read-modify-write of a 2-way set.
// Optional same-cycle fetch forwarding of the written set is enabled by defining BTB_UPD_FWD_EN.
module btb_update_ctrl (
  input  logic                    clk,
  input  logic                    rst,
  btb_update_ctrl_if.slave        upd,
  output logic [2:0]              rd_index,
  input  logic [127:0]            rd_set,
  input  logic [7:0]              lru,
  output logic                    wr_en,
  output logic [2:0]              wr_index,
  output logic [127:0]            wr_set,
  output logic                    lru_wr_en,
  output logic [2:0]              lru_wr_index,
  output logic                    lru_wr_val,
  input  logic [2:0]              fetch_index,
  output logic                    fwd_hit,
  output logic [127:0]            fwd_set,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [31:0]   pc_mem_r  [2];
  logic [31:0]   tgt_mem_r [2];
  logic [1:0]    taken_mem_r;
  logic          rd_ptr_r, wr_ptr_r;
  logic [1:0]    count_r;
  logic          push_s, pop_s;
  logic [31:0]   head_pc_s, head_tgt_s;
  logic          head_taken_s;
  logic [2:0]    head_idx_s;
  logic [26:0]   head_tag_s;
  logic [63:0]   way0_s, way1_s, old_way_s, new_way_s;
  logic          hit0_s, hit1_s, sel_s, new_en_s;
  logic [127:0]  new_set_s;
  logic          wr_en_r, lru_val_r;
  logic [2:0]    wr_index_r;
  logic [127:0]  wr_set_r;
  logic          pc_lo_unused_s;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (ctr == 2'b11) res = 2'b11;
      else              res = ctr + 2'b01;
    end else begin
      if (ctr == 2'b00) res = 2'b00;
      else              res = ctr - 2'b01;
    end
    return res;
  endfunction

  // A full FIFO refuses input even while the head is being popped.
  assign upd.upd_ready = (count_r != 2'd2);
  assign push_s        = upd.upd_valid && (count_r != 2'd2);
  assign pop_s         = (state_r == ST_WRITE);
  assign head_pc_s     = pc_mem_r[rd_ptr_r];
  assign head_tgt_s    = tgt_mem_r[rd_ptr_r];
  assign head_taken_s  = taken_mem_r[rd_ptr_r];
  assign head_idx_s    = head_pc_s[4:2];
  assign head_tag_s    = head_pc_s[31:5];
  assign pc_lo_unused_s = ^head_pc_s[1:0];
  assign busy          = (count_r != 2'd0) || (state_r != ST_IDLE);

  // Request FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_mem_r[0]  <= 32'd0;
      pc_mem_r[1]  <= 32'd0;
      tgt_mem_r[0] <= 32'd0;
      tgt_mem_r[1] <= 32'd0;
      taken_mem_r  <= 2'b00;
      rd_ptr_r     <= 1'b0;
      wr_ptr_r     <= 1'b0;
      count_r      <= 2'd0;
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]    <= upd.upd_pc;
        tgt_mem_r[wr_ptr_r]   <= upd.upd_target;
        taken_mem_r[wr_ptr_r] <= upd.upd_taken;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // FSM next state; WRITE chains straight into READ only for an entry already stored behind the head.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (count_r != 2'd0) state_nxt_s = ST_READ;
        else                 state_nxt_s = ST_IDLE;
      end
      ST_READ:  state_nxt_s = ST_WRITE;
      ST_WRITE: begin
        if (count_r == 2'd2) state_nxt_s = ST_READ;
        else                 state_nxt_s = ST_IDLE;
      end
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Set read index, only meaningful during READ.
  always_comb begin
    rd_index = 3'd0;
    if (state_r == ST_READ) rd_index = head_idx_s;
    else                    rd_index = 3'd0;
  end

  // Tag compare, counter update and victim choice on the set returned this cycle.
  always_comb begin
    way0_s    = rd_set[63:0];
    way1_s    = rd_set[127:64];
    hit0_s    = way0_s[63] && (way0_s[62:36] == head_tag_s);
    hit1_s    = way1_s[63] && (way1_s[62:36] == head_tag_s);
    sel_s     = 1'b0;
    old_way_s = 64'd0;
    new_way_s = 64'd0;
    new_en_s  = 1'b0;
    new_set_s = 128'd0;
    if (hit0_s || hit1_s) begin
      sel_s           = !hit0_s;
      old_way_s       = sel_s ? way1_s : way0_s;
      new_way_s       = old_way_s;
      new_way_s[3:2]  = ctr_next(old_way_s[3:2], head_taken_s);
      if (head_taken_s) new_way_s[35:4] = head_tgt_s;
      else              new_way_s[35:4] = old_way_s[35:4];
      new_en_s        = 1'b1;
    end else if (head_taken_s) begin
      if (!way0_s[63])      sel_s = 1'b0;
      else if (!way1_s[63]) sel_s = 1'b1;
      else                  sel_s = lru[head_idx_s];
      new_way_s = {1'b1, head_tag_s, head_tgt_s, 2'b10, 2'b00};
      new_en_s  = 1'b1;
    end else begin
      new_en_s  = 1'b0;
    end
    if (!new_en_s)  new_set_s = 128'd0;
    else if (sel_s) new_set_s = {new_way_s, way0_s};
    else            new_set_s = {way1_s, new_way_s};
  end

  // Write port registers: loaded at the end of READ so they are live for exactly the WRITE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_r    <= 1'b0;
      wr_index_r <= 3'd0;
      wr_set_r   <= 128'd0;
      lru_val_r  <= 1'b0;
    end else if ((state_r == ST_READ) && new_en_s) begin
      wr_en_r    <= 1'b1;
      wr_index_r <= head_idx_s;
      wr_set_r   <= new_set_s;
      lru_val_r  <= ~sel_s;
    end else begin
      wr_en_r    <= 1'b0;
      wr_index_r <= 3'd0;
      wr_set_r   <= 128'd0;
      lru_val_r  <= 1'b0;
    end
  end

  assign wr_en        = wr_en_r;
  assign wr_index     = wr_index_r;
  assign wr_set       = wr_set_r;
  assign lru_wr_en    = wr_en_r;
  assign lru_wr_index = wr_index_r;
  assign lru_wr_val   = lru_val_r;

`ifdef BTB_UPD_FWD_EN
  // Forward the set being written to a fetch reading the same index this cycle.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_set = 128'd0;
    if (wr_en_r && (fetch_index == wr_index_r)) begin
      fwd_hit = 1'b1;
      fwd_set = wr_set_r;
    end else begin
      fwd_hit = 1'b0;
      fwd_set = 128'd0;
    end
  end
`else
  logic fetch_unused_s;
  assign fetch_unused_s = ^fetch_index;
  assign fwd_hit        = 1'b0;
  assign fwd_set        = 128'd0;
`endif

endmodule

// File: doc/btb_update_ctrl.md
# btb_update_ctrl

Sequencer for branch target buffer (BTB) updates. It accepts resolved-branch updates from the EX stage and buffers them in a 2-entry FIFO. For each update it runs a read-modify-write of one 2-way BTB set: tag compare, 2-bit counter update, victim selection and LRU bit update. It sits between branch resolution and the BTB storage/LRU register, and owns both of their write ports.

## Interface
- No parameters. Geometry is fixed: 8 sets × 2 ways; PC split is tag = pc[31:5], index = pc[4:2].
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- upd_valid  input  1  update request
- upd_ready  output  1  request accepted when upd_valid && upd_ready
- upd_pc  input  32  branch PC
- upd_target  input  32  resolved target
- upd_taken  input  1  resolved outcome
- rd_index  output  3  BTB set read index; the file returns rd_set combinationally in the same cycle
- rd_set  input  128  set contents
- lru  input  8  LRU vector; bit i = victim way of set i
- wr_en  output  1  BTB set write strobe; the file writes on the clock edge
- wr_index  output  3  set to write
- wr_set  output  128  new set contents
- lru_wr_en  output  1  LRU bit write strobe
- lru_wr_index  output  3  LRU bit index
- lru_wr_val  output  1  new LRU bit
- fetch_index  input  3  index being read by fetch this cycle
- fwd_hit  output  1  forward valid (see Configuration)
- fwd_set  output  128  forwarded set
- busy  output  1  FIFO non-empty or FSM not in IDLE

## Operation
- Way layout within a set:
  - way0 = [63:0], way1 = [127:64].
  - Per way: [63] valid, [62:36] tag, [35:4] target, [3:2] counter, [1:0] = 0.
- FIFO:
  - 2 entries, each holding {pc, target, taken}.
  - upd_ready = (count != 2). A full FIFO refuses input even in a pop cycle.
- FSM states IDLE, READ, WRITE:
  - IDLE → READ when FIFO is non-empty.
  - READ: drive rd_index = head pc[4:2] and register rd_set → WRITE.
  - WRITE: drive all write outputs for exactly one cycle and pop the head. Then go → READ if another entry remains, else → IDLE.
- Modify rules, where hit = way valid && way tag == pc[31:5]:
  - Hit on way w:
    - counter saturating +1 if taken, −1 if not taken.
    - target replaced only if taken.
    - wr_en = 1, lru_wr_val = ~w.
  - Miss, taken:
    - Victim is the first invalid way, way0 preferred, else way lru[index].
    - Victim written with valid = 1, tag, target, counter = 2'b10.
    - The other way is unchanged; wr_en = 1, lru_wr_val = ~victim.
  - Miss, not taken: wr_en = 0, lru_wr_en = 0. The entry is still popped.
  - Both ways hitting is illegal; way0 takes priority.
- lru_wr_en equals wr_en, and lru_wr_index equals wr_index.
- When not in WRITE, all write outputs are 0. rd_index = 0 when not in READ.

## Timing
- Reset (asserted, asynchronous):
  - FIFO emptied, FSM → IDLE, so upd_ready = 1.
  - busy, wr_en, lru_wr_en, fwd_hit = 0; all data outputs 0.
- Reset mid-operation: any pending write is aborted immediately and queued entries are discarded.
- Latency: for a request accepted in cycle T, READ occurs in T+2 and wr_en is asserted in T+3.
- Throughput: one update per 2 cycles with back-to-back WRITE → READ.
- Same-index updates in consecutive entries: the READ of entry 2 follows the edge that committed entry 1, so entry 2 sees entry 1's data.
- Push and pop in the same cycle are allowed when count < 2; count is unchanged.

## Configuration
- BTB_UPD_FWD_EN defined:
  - fwd_hit = wr_en && (fetch_index == wr_index).
  - fwd_set = wr_set when fwd_hit, else 0.
  - Fetch uses fwd_set in place of the stale file data.
- BTB_UPD_FWD_EN undefined: fwd_hit and fwd_set are tied to 0; fetch sees the update one cycle later.

## Test plan
- Reset, then a single update (pc=0x0000_0040, target=0x0000_0100, taken=1) into an empty set → wr_en asserted at T+3 with wr_index=0; way0 = {valid=1, tag=0x2, target=0x100, ctr=2'b10}; lru_wr_val=1.
- Same pc with taken=1 twice, then taken=0 four times → counter 11, 11, 10, 01, 00, 00; target unchanged on the not-taken updates.
- Set 0 has both ways valid with lru[0]=1; a taken miss → way1 replaced, way0 bits identical, lru_wr_val=0.
- Not-taken miss → wr_en stays 0 and the FIFO pops; busy drops 1 cycle after the WRITE slot.
- Hold upd_valid=1 with 4 requests → upd_ready=0 while 2 are queued; all 4 writes occur, at cycles spaced 2 apart, in order.
- Assert rst during READ with 2 entries queued → no write ever occurs and upd_ready=1 after release. With BTB_UPD_FWD_EN, fetch_index==wr_index in the WRITE cycle → fwd_hit=1 and fwd_set==wr_set.
